// File: rtl/div_request_ctrl.sv
// Requester side of the pipelined-divider handshake: one divide job in flight,
// operands held stable toward the divider, quotient returned on a valid/ready port.
module div_request_ctrl #(
  parameter int WIDTH    = 20,
  parameter int LATENCY  = 24,
  parameter int MIN_WAIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic             out_err,
  output logic             busy,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic             div_done
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] MIN_C = CW'(MIN_WAIT);
  localparam logic [CW-1:0] LAT_C = CW'(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          capture;
  logic          zero_div;

  assign zero_div  = (in_divisor == '0);
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    capture  = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = zero_div ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        // A done pulse this early belongs to the previous job; the latency
        // bound covers equal back-to-back quotients that raise no pulse.
        if ((div_done && (cnt >= MIN_C)) || (cnt == LAT_C)) begin
          capture  = 1'b1;
          state_nx = S_RESP;
        end
      end
      S_RESP: begin
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      out_quotient <= '0;
      out_err      <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        div_dividend <= in_dividend;
        div_divisor  <= in_divisor;
        cnt          <= '0;
        if (zero_div) begin
          out_quotient <= '1;
          out_err      <= 1'b1;
        end else begin
          out_err      <= 1'b0;
        end
      end
      if (capture) begin
        out_quotient <= div_quotient;
      end else if (state == S_WAIT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
